// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the decode-side hazard unit: shadow pipeline entry,
// forward-select encoding and register-address width helper.
package hazard_scoreboard_pkg;

    // Forward-select value meaning "take operand from the register file".
    localparam int FWD_RF = 0;

    // Shadow entries carry rd at a fixed width; narrower register
    // addresses are zero-extended into it (covers up to 256 registers).
    localparam int SHD_AW = 8;

    function automatic int reg_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic              valid;
        logic [SHD_AW-1:0] rd;
        logic              wren;
        logic              mem_to_reg;
    } shadow_t;

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow copy of destination info for the FWD_STAGES stages behind decode.
// Ports: i_push loads i_entry into stage 1 (else a bubble); o_entries[k] = stage k.
module hazard_shadow_pipe
    import hazard_scoreboard_pkg::*;
#(
    parameter int FWD_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  shadow_t                  i_entry,
    output shadow_t [FWD_STAGES:1]   o_entries
);

    shadow_t [FWD_STAGES:1] r_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[1] <= i_push ? i_entry : '0;
            for (int k = 2; k <= FWD_STAGES; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    assign o_entries = r_pipe;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard unit: operand forwarding selects, load-use / long-op
// stall, busy scoreboard for one long op, saturating stall counter.
// Ports: id_* decode fields, flush, long_done/long_rd writeback;
// outputs fwd_a/fwd_b, should_stall, long_busy, stall_cycles.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 32,
    parameter int REG_AW     = reg_aw(NUM_REGS),
    parameter int SEL_W      = reg_aw(FWD_STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_wrenable,
    input  logic              id_mem_to_reg,
    input  logic              id_long_op,
    input  logic              flush,
    input  logic              long_done,
    input  logic [REG_AW-1:0] long_rd,
    output logic [SEL_W-1:0]  fwd_a,
    output logic [SEL_W-1:0]  fwd_b,
    output logic              should_stall,
    output logic              long_busy,
    output logic [CNT_W-1:0]  stall_cycles
);

    shadow_t [FWD_STAGES:1] w_ent;
    shadow_t                w_new;
    logic [FWD_STAGES:1]    w_live;
    logic                   w_issue;
    logic                   w_lu;
    logic                   w_raw;
    logic                   w_waw;
    logic                   w_struct;
    logic                   w_long_set;
    logic [NUM_REGS-1:0]    w_done_mask;
    logic [NUM_REGS-1:0]    w_set_mask;
    logic [NUM_REGS-1:0]    w_busy_eff;

    logic [NUM_REGS-1:0]    r_busy;
    logic                   r_pend;
    logic [CNT_W-1:0]       r_cnt;

    always_comb begin
        w_new            = '0;
        w_new.valid      = 1'b1;
        w_new.rd         = SHD_AW'(id_rd);
        w_new.wren       = id_reg_wrenable;
        w_new.mem_to_reg = id_mem_to_reg;
    end

    hazard_shadow_pipe #(
        .FWD_STAGES (FWD_STAGES)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_issue && !id_long_op),
        .i_entry   (w_new),
        .o_entries (w_ent)
    );

    // A writeback this cycle releases its register immediately.
    assign w_done_mask = long_done ? (NUM_REGS'(1) << long_rd) : '0;
    assign w_busy_eff  = r_busy & ~w_done_mask;

    always_comb begin
        fwd_a  = SEL_W'(FWD_RF);
        fwd_b  = SEL_W'(FWD_RF);
        w_lu   = 1'b0;
        w_live = '0;
        // Walk oldest to youngest so the youngest match is left standing.
        for (int k = FWD_STAGES; k >= 1; k--) begin
            w_live[k] = w_ent[k].valid && w_ent[k].wren &&
                        (w_ent[k].rd != '0);
            if (w_live[k] && id_rs1_used &&
                w_ent[k].rd == SHD_AW'(id_rs1)) begin
                fwd_a = SEL_W'(k);
                if (w_ent[k].mem_to_reg && k < LOAD_STAGE) w_lu = 1'b1;
            end
            if (w_live[k] && id_rs2_used &&
                w_ent[k].rd == SHD_AW'(id_rs2)) begin
                fwd_b = SEL_W'(k);
                if (w_ent[k].mem_to_reg && k < LOAD_STAGE) w_lu = 1'b1;
            end
        end
    end

    assign long_busy = (|r_busy) || r_pend;

    assign w_raw = (id_rs1_used && id_rs1 != '0 && w_busy_eff[id_rs1]) ||
                   (id_rs2_used && id_rs2 != '0 && w_busy_eff[id_rs2]);
    assign w_waw    = id_reg_wrenable && w_busy_eff[id_rd];
    assign w_struct = id_long_op && long_busy && !long_done;

    assign should_stall = id_valid && !flush &&
                          (w_lu || w_raw || w_waw || w_struct);

    assign w_issue    = id_valid && !should_stall && !flush;
    assign w_long_set = w_issue && id_long_op && id_reg_wrenable &&
                        (id_rd != '0);
    assign w_set_mask = w_long_set ? (NUM_REGS'(1) << id_rd) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            r_pend <= 1'b0;
            r_cnt  <= '0;
        end else begin
            // Clear then set: a same-register set wins.
            r_busy <= w_busy_eff | w_set_mask;
            // Long op with no tracked destination still occupies the unit.
            if (w_issue && id_long_op && !w_long_set) r_pend <= 1'b1;
            else if (long_done)                      r_pend <= 1'b0;
            if (should_stall && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign stall_cycles = r_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus
// randomized traffic checked against an instruction-history model.
module tb_hazard_scoreboard;

    localparam int S    = 2;
    localparam int LDS  = 2;
    localparam int NR   = 32;
    localparam int CMAX = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid, id_rs1_used, id_rs2_used;
    logic [4:0] id_rs1, id_rs2, id_rd, long_rd;
    logic       id_reg_wrenable, id_mem_to_reg, id_long_op;
    logic       flush, long_done;
    logic [1:0] fwd_a, fwd_b;
    logic       should_stall, long_busy;
    logic [3:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_scoreboard #(
        .NUM_REGS   (NR),
        .FWD_STAGES (S),
        .LOAD_STAGE (LDS),
        .CNT_W      (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_rd           (id_rd),
        .id_reg_wrenable (id_reg_wrenable),
        .id_mem_to_reg   (id_mem_to_reg),
        .id_long_op      (id_long_op),
        .flush           (flush),
        .long_done       (long_done),
        .long_rd         (long_rd),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .should_stall    (should_stall),
        .long_busy       (long_busy),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    // Reference model: history of issued non-long instructions by
    // issue cycle, a set of registers owed by the long unit, a pending flag.
    typedef struct {
        int cyc;
        int rd;
        bit wren;
        bit ld;
    } rec_t;

    rec_t m_q[$];
    bit   m_busy[NR];
    bit   m_pend;
    int   m_cnt;
    int   m_cycle;

    int e_a, e_b, e_cnt;
    bit e_st, e_lb;

    task automatic model_reset();
        m_q.delete();
        foreach (m_busy[i]) m_busy[i] = 0;
        m_pend  = 0;
        m_cnt   = 0;
        m_cycle = 0;
    endtask

    function automatic bit owed(int r);
        return m_busy[r] && !(long_done && int'(long_rd) == r);
    endfunction

    task automatic model_eval();
        bit lu, raw, waw, st, any;
        int age;
        e_a = 0;
        e_b = 0;
        lu  = 0;
        foreach (m_q[i]) begin
            age = m_cycle - m_q[i].cyc;
            if (m_q[i].wren && m_q[i].rd != 0) begin
                if (id_rs1_used && int'(id_rs1) == m_q[i].rd) begin
                    if (e_a == 0 || age < e_a) e_a = age;
                    if (m_q[i].ld && age < LDS) lu = 1;
                end
                if (id_rs2_used && int'(id_rs2) == m_q[i].rd) begin
                    if (e_b == 0 || age < e_b) e_b = age;
                    if (m_q[i].ld && age < LDS) lu = 1;
                end
            end
        end
        any = m_pend;
        foreach (m_busy[i]) any = any | m_busy[i];
        raw = (id_rs1_used && id_rs1 != 0 && owed(int'(id_rs1))) ||
              (id_rs2_used && id_rs2 != 0 && owed(int'(id_rs2)));
        waw = id_reg_wrenable && owed(int'(id_rd));
        st  = id_long_op && any && !long_done;
        e_st  = id_valid && !flush && (lu || raw || waw || st);
        e_lb  = any;
        e_cnt = m_cnt;
    endtask

    task automatic model_commit();
        bit issue;
        model_eval();
        issue = id_valid && !e_st && !flush;
        if (long_done) begin
            m_busy[long_rd] = 0;
            m_pend = 0;
        end
        if (issue && id_long_op) begin
            if (id_reg_wrenable && id_rd != 0) m_busy[id_rd] = 1;
            else m_pend = 1;
        end else if (issue) begin
            m_q.push_back('{m_cycle, int'(id_rd), id_reg_wrenable,
                            id_mem_to_reg});
        end
        if (e_st && m_cnt < CMAX) m_cnt++;
        m_cycle++;
        while (m_q.size() > 0 && m_cycle - m_q[0].cyc > S) m_q.pop_front();
    endtask

    task automatic set_id(bit v, int rs1, bit u1, int rs2, bit u2,
                          int rd, bit we, bit ld, bit lo);
        id_valid        = v;
        id_rs1          = 5'(rs1);
        id_rs1_used     = u1;
        id_rs2          = 5'(rs2);
        id_rs2_used     = u2;
        id_rd           = 5'(rd);
        id_reg_wrenable = we;
        id_mem_to_reg   = ld;
        id_long_op      = lo;
        flush           = 0;
        long_done       = 0;
        long_rd         = 0;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        id_valid = 1;
        id_rs1 = 5;
        id_rs1_used = 1;
        rst = 1;
        model_reset();
        #1;
        n_tests += 5;
        if (fwd_a !== 2'd0) begin
            n_fail++; $display("FAIL reset_fwd_a got %0d want 0", fwd_a);
        end
        if (fwd_b !== 2'd0) begin
            n_fail++; $display("FAIL reset_fwd_b got %0d want 0", fwd_b);
        end
        if (should_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall got %b want 0", should_stall);
        end
        if (long_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b want 0", long_busy);
        end
        if (stall_cycles !== 4'd0) begin
            n_fail++; $display("FAIL reset_cnt got %0d want 0", stall_cycles);
        end
        @(posedge clk);
        #1;
        rst = 0;
        idle();
        #1;
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 1, 0);
        #1;
        tick();
        set_id(1, 5, 1, 5, 1, 6, 1, 0, 0);
        #1;
        n_tests++;
        if (should_stall !== 1'b1) begin
            n_fail++; $display("FAIL load_use_stall got %b want 1", should_stall);
        end
        tick();
        #1;
        n_tests += 4;
        if (should_stall !== 1'b0) begin
            n_fail++; $display("FAIL load_use_release got %b want 0", should_stall);
        end
        if (fwd_a !== 2'd2) begin
            n_fail++; $display("FAIL load_fwd_a got %0d want 2", fwd_a);
        end
        if (fwd_b !== 2'd2) begin
            n_fail++; $display("FAIL load_fwd_b got %0d want 2", fwd_b);
        end
        if (stall_cycles !== 4'd1) begin
            n_fail++; $display("FAIL load_cnt got %0d want 1", stall_cycles);
        end
        tick();
        idle();
    endtask

    task automatic test_alu_fwd();
        do_reset();
        set_id(1, 1, 1, 2, 1, 3, 1, 0, 0);
        #1;
        tick();
        set_id(1, 3, 1, 3, 1, 4, 1, 0, 0);
        #1;
        n_tests += 3;
        if (fwd_a !== 2'd1 || fwd_b !== 2'd1) begin
            n_fail++; $display("FAIL alu_fwd got %0d/%0d want 1/1", fwd_a, fwd_b);
        end
        if (should_stall !== 1'b0) begin
            n_fail++; $display("FAIL alu_stall got %b want 0", should_stall);
        end
        tick();
        do_reset();
        set_id(1, 1, 1, 2, 1, 0, 1, 0, 0);
        #1;
        tick();
        set_id(1, 0, 1, 0, 1, 4, 1, 0, 0);
        #1;
        if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin
            n_fail++; $display("FAIL x0_fwd got %0d/%0d want 0/0", fwd_a, fwd_b);
        end
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_id(1, 1, 1, 0, 0, 7, 1, 0, 0);
        #1;
        tick();
        set_id(1, 2, 1, 0, 0, 7, 1, 0, 0);
        #1;
        tick();
        set_id(1, 7, 1, 7, 1, 8, 1, 0, 0);
        #1;
        n_tests += 2;
        if (fwd_a !== 2'd1 || fwd_b !== 2'd1) begin
            n_fail++; $display("FAIL b2b_fwd got %0d/%0d want 1/1", fwd_a, fwd_b);
        end
        model_eval();
        if (fwd_a !== 2'(e_a)) begin
            n_fail++; $display("FAIL b2b_model got %0d want %0d", fwd_a, e_a);
        end
        tick();
        idle();
    endtask

    task automatic test_long_op();
        do_reset();
        set_id(1, 1, 1, 2, 1, 9, 1, 0, 1);
        #1;
        n_tests++;
        if (should_stall !== 1'b0) begin
            n_fail++; $display("FAIL div_issue_stall got %b want 0", should_stall);
        end
        tick();
        set_id(1, 9, 1, 0, 0, 11, 1, 0, 0);
        #1;
        n_tests += 2;
        if (long_busy !== 1'b1) begin
            n_fail++; $display("FAIL div_busy got %b want 1", long_busy);
        end
        if (should_stall !== 1'b1) begin
            n_fail++; $display("FAIL div_raw got %b want 1", should_stall);
        end
        tick();
        tick();
        long_done = 1;
        long_rd   = 9;
        #1;
        n_tests++;
        if (should_stall !== 1'b0) begin
            n_fail++; $display("FAIL div_release got %b want 0", should_stall);
        end
        tick();
        set_id(1, 1, 1, 0, 0, 9, 1, 0, 1);
        #1;
        tick();
        set_id(1, 1, 1, 0, 0, 10, 1, 0, 1);
        #1;
        n_tests += 2;
        if (should_stall !== 1'b1) begin
            n_fail++; $display("FAIL div_struct got %b want 1", should_stall);
        end
        model_eval();
        if (stall_cycles !== 4'(e_cnt)) begin
            n_fail++; $display("FAIL div_cnt got %0d want %0d", stall_cycles, e_cnt);
        end
        tick();
        long_done = 1;
        long_rd   = 9;
        #1;
        n_tests++;
        if (should_stall !== 1'b0) begin
            n_fail++; $display("FAIL div_handoff got %b want 0", should_stall);
        end
        tick();
        idle();
        long_done = 1;
        long_rd   = 10;
        #1;
        tick();
        idle();
        #1;
        n_tests++;
        if (long_busy !== 1'b0) begin
            n_fail++; $display("FAIL div_idle got %b want 0", long_busy);
        end
    endtask

    task automatic test_flush_reset();
        do_reset();
        set_id(1, 0, 0, 0, 0, 9, 1, 0, 1);
        #1;
        tick();
        set_id(1, 9, 1, 0, 0, 11, 1, 0, 0);
        flush = 1;
        #1;
        n_tests++;
        if (should_stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall got %b want 0", should_stall);
        end
        tick();
        set_id(1, 11, 1, 0, 0, 12, 1, 0, 0);
        #1;
        n_tests++;
        if (fwd_a !== 2'd0) begin
            n_fail++; $display("FAIL flush_entry got %0d want 0", fwd_a);
        end
        tick();
        set_id(1, 9, 1, 0, 0, 13, 1, 0, 0);
        #1;
        n_tests++;
        if (should_stall !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_stall got %b want 1", should_stall);
        end
        rst = 1;
        model_reset();
        #1;
        n_tests++;
        if (should_stall !== 1'b0 || long_busy !== 1'b0 ||
            stall_cycles !== 4'd0 || fwd_a !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_reset got st=%b lb=%b cnt=%0d fa=%0d want 0/0/0/0",
                     should_stall, long_busy, stall_cycles, fwd_a);
        end
        @(posedge clk);
        #1;
        rst = 0;
        idle();
        #1;
    endtask

    task automatic test_saturation();
        do_reset();
        set_id(1, 0, 0, 0, 0, 9, 1, 0, 1);
        #1;
        tick();
        set_id(1, 9, 1, 0, 0, 14, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            #1;
            tick();
        end
        #1;
        n_tests++;
        if (stall_cycles !== 4'd15) begin
            n_fail++; $display("FAIL sat_cnt got %0d want 15", stall_cycles);
        end
        long_done = 1;
        long_rd   = 9;
        #1;
        tick();
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 80 == 79) do_reset();
            set_id($urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), 1'($urandom),
                   $urandom_range(0, 7), 1'($urandom),
                   $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
            flush     = $urandom_range(0, 9) == 0;
            long_done = $urandom_range(0, 4) == 0;
            long_rd   = 5'($urandom_range(0, 7));
            #1;
            model_eval();
            n_tests++;
            if (fwd_a !== 2'(e_a) || fwd_b !== 2'(e_b) ||
                should_stall !== e_st || long_busy !== e_lb ||
                stall_cycles !== 4'(e_cnt)) begin
                n_fail++;
                $display("FAIL rand[%0d] got fa=%0d fb=%0d st=%b lb=%b cnt=%0d want fa=%0d fb=%0d st=%b lb=%b cnt=%0d",
                         i, fwd_a, fwd_b, should_stall, long_busy, stall_cycles,
                         e_a, e_b, e_st, e_lb, e_cnt);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_load_use();
        test_alu_fwd();
        test_back_to_back();
        test_long_op();
        test_flush_reset();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
